// File: rtl/la_sample_packer.sv
`timescale 1ns/1ps
// Drain stage for the logic-analyzer sample FIFO: packs PACK_NUM samples LSB-first
// into one word on a valid/ready stream, with a flush that emits a tagged final word.
module la_sample_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_NUM   = 4,
  parameter int BW         = $clog2(PACK_NUM) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_dout,
  output logic                           fifo_ren,
  input  logic                           flush,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH*PACK_NUM-1:0] m_data,
  output logic [BW-1:0]                  m_bytes,
  output logic                           m_last,
  output logic                           flush_done,
  output logic                           busy
);

  localparam int            LW   = DATA_WIDTH * PACK_NUM;
  localparam logic [BW-1:0] FULL = BW'(PACK_NUM);

  typedef enum logic [1:0] {RUN, DRAIN, EMIT, WAIT} state_t;

  state_t          state;
  logic [LW-1:0]   pack_reg;
  logic [BW-1:0]   pack_cnt;
  logic            rd_pend;

  logic            out_free;
  logic            drain_end;
  logic            xfer_ok;
  logic            xfer;
  logic            emit_load;
  logic            clear;
  logic [BW:0]     fill;
  logic [BW-1:0]   base;
  logic [BW-1:0]   cnt_next;
  logic [LW-1:0]   pack_next;

  assign out_free  = !m_valid || m_ready;
  // Once the FIFO is dry with nothing in flight, the held samples leave via EMIT tagged last.
  assign drain_end = (state == DRAIN) && fifo_empty && !rd_pend;
  assign xfer_ok   = (state == RUN) || ((state == DRAIN) && !drain_end);
  assign xfer      = (pack_cnt == FULL) && out_free && xfer_ok;
  assign emit_load = (state == EMIT) && out_free && (pack_cnt != '0);
  assign clear     = xfer || emit_load;

  assign fill      = {1'b0, pack_cnt} + (BW+1)'(rd_pend);
  assign fifo_ren  = !fifo_empty && ((state == RUN) || (state == DRAIN)) &&
                     ((fill < (BW+1)'(PACK_NUM)) || xfer);

  // An arriving sample lands after the clear, so it starts the next word in lane 0.
  assign base      = clear ? '0 : pack_cnt;
  assign cnt_next  = rd_pend ? base + BW'(1) : base;

  genvar gi;
  generate
    for (gi = 0; gi < PACK_NUM; gi++) begin : g_lane
      assign pack_next[gi*DATA_WIDTH +: DATA_WIDTH] =
        (rd_pend && (base == BW'(gi))) ? fifo_dout :
        clear                          ? '0        :
                                         pack_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign flush_done = (state == WAIT) && !m_valid;
  assign busy       = (state != RUN) || (pack_cnt != '0) || rd_pend || m_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pack_reg <= '0;
      pack_cnt <= '0;
      rd_pend  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_bytes  <= '0;
      m_last   <= 1'b0;
    end else begin
      pack_reg <= pack_next;
      pack_cnt <= cnt_next;
      rd_pend  <= fifo_ren;

      if (xfer) begin
        m_data  <= pack_reg;
        m_bytes <= FULL;
        m_last  <= 1'b0;
        m_valid <= 1'b1;
      end else if (emit_load) begin
        m_data  <= pack_reg;
        m_bytes <= pack_cnt;
        m_last  <= 1'b1;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        RUN:     if (flush)     state <= DRAIN;
        DRAIN:   if (drain_end) state <= EMIT;
        EMIT:    if (out_free)  state <= WAIT;
        WAIT:    if (!m_valid)  state <= RUN;
        default:                state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_la_sample_packer.sv
`timescale 1ns/1ps
// Directed bench for la_sample_packer: a behavioural FIFO feeds the packer and a
// negedge monitor logs every accepted word and flush_done pulse.
module tb_la_sample_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_ren;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [2:0]  m_bytes;
  logic        m_last;
  logic        flush_done;
  logic        busy;

  always #5 clk = ~clk;

  la_sample_packer #(.DATA_WIDTH(8), .PACK_NUM(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_ren(fifo_ren), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_bytes(m_bytes), .m_last(m_last),
    .flush_done(flush_done), .busy(busy)
  );

  // Synchronous FIFO model: data appears the cycle after the pop.
  logic [7:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_ren && !fifo_empty) begin
      fifo_dout <= fmem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
      pops      <= pops + 1;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] rx_data [$];
  logic [2:0]  rx_bytes [$];
  logic        rx_last [$];
  int acc_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      rx_data.push_back(m_data);
      rx_bytes.push_back(m_bytes);
      rx_last.push_back(m_last);
      acc_cyc = cyc;
      $display("cycle %0d word data=%08h bytes=%0d last=%0d", cyc, m_data, m_bytes, m_last);
    end
    if (rst_n && flush_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      $display("cycle %0d flush_done", cyc);
    end
    total = total + 1;
    if (fifo_ren && fifo_empty) begin
      bad = bad + 1;
      $display("FAIL ren_while_empty: fifo_ren=1 with fifo_empty=1 at cycle %0d, required no pop", cyc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr % 256] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_bytes.delete();
    rx_last.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_data.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      flush   = 1'($urandom_range(1));
      m_ready = 1'($urandom_range(1));
      step();
      total++;
      if ({fifo_ren, m_valid, m_data, m_bytes, m_last, flush_done, busy} !== 39'd0) begin
        bad++;
        $display("FAIL reset_outputs: got ren=%0b valid=%0b data=%08h bytes=%0d last=%0b done=%0b busy=%0b, required all 0",
                 fifo_ren, m_valid, m_data, m_bytes, m_last, flush_done, busy);
      end
    end
    flush   = 1'b0;
    m_ready = 1'b0;
    rst_n   = 1'b1;
    step(2);
    total++;
    if (fifo_ren !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ren: got %0b, required 0", fifo_ren);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got %0b, required 0", busy);
    end
  endtask

  task automatic test_streaming();
    int p0;
    clear_rx();
    m_ready = 1'b1;
    p0 = pops;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_rx(2, 80);
    wait_idle(40);
    total++;
    if (rx_data.size() !== 2) begin
      bad++;
      $display("FAIL stream_count: got %0d words, required 2", rx_data.size());
    end else begin
      total++;
      if (rx_data[0] !== 32'h04030201 || rx_bytes[0] !== 3'd4 || rx_last[0] !== 1'b0) begin
        bad++;
        $display("FAIL stream_word0: got %08h/%0d/%0b, required 04030201/4/0", rx_data[0], rx_bytes[0], rx_last[0]);
      end
      total++;
      if (rx_data[1] !== 32'h08070605 || rx_bytes[1] !== 3'd4 || rx_last[1] !== 1'b0) begin
        bad++;
        $display("FAIL stream_word1: got %08h/%0d/%0b, required 08070605/4/0", rx_data[1], rx_bytes[1], rx_last[1]);
      end
    end
    total++;
    if (pops - p0 !== 8) begin
      bad++;
      $display("FAIL stream_pops: got %0d, required 8", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    clear_rx();
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 12; i++) push(8'(i));
    step(40);
    total++;
    if (pops - p0 !== 8) begin
      bad++;
      $display("FAIL bp_pops_stalled: got %0d, required 8", pops - p0);
    end
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'h04030201 || m_bytes !== 3'd4) begin
      bad++;
      $display("FAIL bp_held_word: got valid=%0b data=%08h bytes=%0d, required 1/04030201/4", m_valid, m_data, m_bytes);
    end
    m_ready = 1'b1;
    wait_rx(3, 80);
    wait_idle(40);
    total++;
    if (rx_data.size() !== 3) begin
      bad++;
      $display("FAIL bp_count: got %0d words, required 3", rx_data.size());
    end else begin
      total++;
      if (rx_data[0] !== 32'h04030201 || rx_data[1] !== 32'h08070605 || rx_data[2] !== 32'h0C0B0A09) begin
        bad++;
        $display("FAIL bp_order: got %08h %08h %08h, required 04030201 08070605 0C0B0A09", rx_data[0], rx_data[1], rx_data[2]);
      end
    end
    total++;
    if (pops - p0 !== 12) begin
      bad++;
      $display("FAIL bp_pops_total: got %0d, required 12", pops - p0);
    end
  endtask

  task automatic test_partial_flush();
    int d0;
    clear_rx();
    m_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 1; i <= 6; i++) push(8'(i));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_done(d0, 80);
    step(5);
    total++;
    if (rx_data.size() !== 2) begin
      bad++;
      $display("FAIL pflush_count: got %0d words, required 2", rx_data.size());
    end else begin
      total++;
      if (rx_data[0] !== 32'h04030201 || rx_bytes[0] !== 3'd4 || rx_last[0] !== 1'b0) begin
        bad++;
        $display("FAIL pflush_word0: got %08h/%0d/%0b, required 04030201/4/0", rx_data[0], rx_bytes[0], rx_last[0]);
      end
      total++;
      if (rx_data[1] !== 32'h00000605 || rx_bytes[1] !== 3'd2 || rx_last[1] !== 1'b1) begin
        bad++;
        $display("FAIL pflush_word1: got %08h/%0d/%0b, required 00000605/2/1", rx_data[1], rx_bytes[1], rx_last[1]);
      end
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL pflush_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
    total++;
    if (done_cyc !== acc_cyc + 1) begin
      bad++;
      $display("FAIL pflush_done_timing: got cycle %0d, required %0d", done_cyc, acc_cyc + 1);
    end
  endtask

  task automatic test_full_flush();
    int d0;
    clear_rx();
    m_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 1; i <= 4; i++) push(8'(i));
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_done(d0, 80);
    step(5);
    total++;
    if (rx_data.size() !== 1) begin
      bad++;
      $display("FAIL fflush_count: got %0d words, required 1", rx_data.size());
    end else begin
      total++;
      if (rx_data[0] !== 32'h04030201 || rx_bytes[0] !== 3'd4 || rx_last[0] !== 1'b1) begin
        bad++;
        $display("FAIL fflush_word: got %08h/%0d/%0b, required 04030201/4/1", rx_data[0], rx_bytes[0], rx_last[0]);
      end
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL fflush_done_count: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_empty_flush();
    logic [3:0] seen;
    logic [3:0] req;
    clear_rx();
    wait_idle(40);
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL eflush_busy: got %0b, required 1", busy);
    end
    seen[0] = flush_done;
    for (int i = 1; i < 4; i++) begin
      step();
      seen[i] = flush_done;
    end
    req = 4'b0100;
    total++;
    if (seen !== req) begin
      bad++;
      $display("FAIL eflush_done_timing: got %b, required %b", seen, req);
    end
    total++;
    if (rx_data.size() !== 0) begin
      bad++;
      $display("FAIL eflush_no_word: got %0d words, required 0", rx_data.size());
    end
  endtask

  task automatic test_double_flush();
    int d0;
    clear_rx();
    m_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 1; i <= 6; i++) push(8'(i + 8'h20));
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_done(d0, 80);
    step(10);
    total++;
    if (rx_data.size() !== 2) begin
      bad++;
      $display("FAIL dflush_count: got %0d words, required 2", rx_data.size());
    end else begin
      total++;
      if (rx_data[1] !== 32'h00002625 || rx_last[1] !== 1'b1) begin
        bad++;
        $display("FAIL dflush_word1: got %08h/%0b, required 00002625/1", rx_data[1], rx_last[1]);
      end
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL dflush_done_count: got %0d, required 1", done_cnt - d0);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL dflush_idle: got busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_reset_midop();
    clear_rx();
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    step(20);
    total++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got valid=%0b busy=%0b, required 1/1", m_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({fifo_ren, m_valid, m_data, m_bytes, m_last, flush_done, busy} !== 39'd0) begin
      bad++;
      $display("FAIL midrst_outputs: got valid=%0b data=%08h bytes=%0d last=%0b busy=%0b, required all 0",
               m_valid, m_data, m_bytes, m_last, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    wait_rx(1, 60);
    wait_idle(40);
    total++;
    if (rx_data.size() !== 1) begin
      bad++;
      $display("FAIL midrst_count: got %0d words, required 1", rx_data.size());
    end else begin
      total++;
      if (rx_data[0] !== 32'h14131211 || rx_bytes[0] !== 3'd4 || rx_last[0] !== 1'b0) begin
        bad++;
        $display("FAIL midrst_word: got %08h/%0d/%0b, required 14131211/4/0", rx_data[0], rx_bytes[0], rx_last[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_partial_flush();
    test_full_flush();
    test_empty_flush();
    test_double_flush();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/la_sample_packer.md
# la_sample_packer

Downstream drain stage for the logic-analyzer sample FIFO. Pops DATA_WIDTH-bit samples from the synchronous FIFO and packs PACK_NUM of them LSB-first into one output word. Presents each word on a valid/ready stream toward the readout/bus side. On request, drains the FIFO completely, emits the final partial word tagged last with a sample count, and signals completion.

## Interface

- DATA_WIDTH, 8, sample width; must equal the FIFO data width.
- PACK_NUM, 4, samples per output word (power of two, ≥2).
- BW, $clog2(PACK_NUM)+1 (derived), width of m_bytes.

- clk  in  1  single clock, shared with the FIFO.
- rst_n  in  1  asynchronous active-low reset (the polarity and synchronicity are fixed).
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_ren.
- fifo_ren  out  1  FIFO pop; combinational.
- flush  in  1  single-cycle pulse: drain FIFO, emit partial word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DATA_WIDTH*PACK_NUM  packed word; sample k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_bytes  out  BW  number of valid samples in m_data (1..PACK_NUM).
- m_last  out  1  final word of a flush.
- flush_done  out  1  one-cycle pulse when the flush has fully completed.
- busy  out  1  state≠RUN, or pack_cnt≠0, or rd_pend, or m_valid.

## Operation

- FIFO pointers advance on every ren. fifo_ren is never asserted while fifo_empty=1.
- Registers:
  - pack_reg and pack_cnt (0..PACK_NUM).
  - rd_pend: ren was issued last cycle.
  - One-deep output register: m_data/m_bytes/m_last/m_valid.
- xfer = pack_cnt==PACK_NUM && (!m_valid || m_ready) && normal transfer allowed (see DRAIN).
- fifo_ren = !fifo_empty && state∈{RUN,DRAIN} && ((pack_cnt + rd_pend < PACK_NUM) || xfer).
- When rd_pend: fifo_dout is written into lane pack_cnt, and pack_cnt increments. On xfer, the sample lands in lane 0 after pack_cnt is cleared.
- On xfer: the output register loads pack_reg with m_bytes=PACK_NUM and m_last=0. m_valid is set, and pack_reg/pack_cnt are cleared.
- The output register holds stable while m_valid && !m_ready. m_valid clears on acceptance unless it is reloaded in the same cycle.
- Unused lanes of a partial word are zero.

FSM:
- **RUN.** Normal packing. flush → DRAIN. flush in any other state is ignored.
- **DRAIN.** Same as RUN.
  - If fifo_empty && !rd_pend, the normal xfer is suppressed and the FSM goes to EMIT.
- **EMIT.** Waits for !m_valid || m_ready.
  - If pack_cnt>0: load the output with m_bytes=pack_cnt and m_last=1, clear the packer, go to WAIT.
  - If pack_cnt==0: go to WAIT with no load.
- **WAIT.** When the output register is empty (!m_valid), pulse flush_done for one cycle and go to RUN.

## Timing

- Reset values:
  - fifo_ren=0 (FIFO is empty out of the same reset).
  - m_valid=0, m_data=0, m_bytes=0, m_last=0, flush_done=0, busy=0.
  - State RUN, pack_cnt=0, rd_pend=0.
- Latency: ren in cycle t → sample in pack_reg at t+1 edge. The word with its 4th sample is registered at t+1; m_valid rises one cycle after the 4th sample arrives.
- Peak throughput: PACK_NUM samples per PACK_NUM+1 cycles with m_ready=1.
- Backpressure: with m_ready=0, at most 2·PACK_NUM samples are removed from the FIFO; reads stop after that.
- flush arriving on the same cycle as a sample arrival or xfer: both take effect; the FSM enters DRAIN next cycle.
- Flush with an empty FIFO and empty packer: flush_done pulses 3 cycles after flush (RUN→DRAIN→EMIT→WAIT→pulse), provided m_valid=0.
- Reset asserted mid-operation clears all state asynchronously. An in-flight flush and any held word are discarded.

## Test plan

- **Reset.** Hold rst_n=0 with random inputs → all outputs 0. After release with the FIFO empty: fifo_ren=0, busy=0.
- **Streaming.** Write 0x01..0x08 with m_ready=1 → words 0x04030201 then 0x08070605, m_bytes=4, m_last=0. No fifo_ren while fifo_empty=1.
- **Backpressure.** m_ready=0 and 12 samples written → exactly 8 pops; m_data stays at 0x04030201. Raise m_ready → 0x08070605 then 0x0C0B0A09, in order with no loss.
- **Partial flush.** 6 samples, then a flush pulse → 0x04030201 (bytes=4, last=0), then 0x00000605 (bytes=2, last=1). flush_done pulses once, the cycle after the last word is accepted.
- **Full and empty flush.**
  - Exactly 4 samples then flush → 0x04030201 with bytes=4, last=1.
  - Flush with nothing buffered → no word, flush_done 3 cycles later.
  - A second flush during DRAIN is ignored.
- **Reset mid-operation.** Drop rst_n while m_valid=1 and pack_cnt=2 → all outputs 0 immediately. The next stream starts clean from lane 0.
